mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory initiator for the pipelined CPU. It accepts one load/store request at a time from the pipeline and drives the single-port, word-wide, single-write-enable data memory (Pipedmem) through its `clka/wea/addra/dina/douta` interface. Byte and halfword stores are implemented as read-modify-write, because the memory has no byte enables. Busy is held while an access is in flight so the hazard unit can stall the pipeline.

## Interface
Parameters:
- `RD_LAT`, default 1: memory read latency; `douta` is valid `RD_LAT` cycles after the edge that samples `addra`.
- `AW`, default 32: byte-address width.

Ports:
- `clk` in 1: single clock; memory `clka` is driven from the same net.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext` in 1: sign-extend sub-word loads.
- `addr` in AW: byte address.
- `wdata` in 32: store data, right-justified.
- `rdata` out 32: load result.
- `busy` out 1: access in flight.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: error flag; valid only while `done` is high.
- `mem_wea` out 1: memory write enable.
- `mem_addra` out 32: word address.
- `mem_dina` out 32: memory write data.
- `mem_douta` in 32: memory read data.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE + `req`: latch `we`, `size`, `sign_ext`, `addr`, and `wdata`.
  - Error case: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11 → go to DONE with `misaligned`=1. No memory cycle is issued.
  - Word store → WR.
  - Load or sub-word store → RD; clear the wait counter.
- RD: lasts RD_LAT+1 cycles. On the last cycle, capture `mem_douta`.
  - Load → DONE, with `rdata` loaded from the extracted value.
  - Sub-word store → WR, with the merged word registered.
- WR: one cycle. `mem_wea`=1; `mem_dina` = `wdata` for a word store, or the merged word otherwise. Next state is DONE.
- DONE: `done`=1 for one cycle, then unconditional return to IDLE.
- `req` is ignored outside IDLE. A back-to-back request is accepted in the cycle after DONE.
- Memory address: `mem_addra` = {2'b00, `addr[AW-1:2]`}. It is driven from the latched address and held stable from RD/WR entry through DONE, and keeps its last value while in IDLE.
- Byte lanes are little-endian. Byte lane = `addr[1:0]` (bits `8*lane+:8`); half lane = `addr[1]` (bits `16*addr[1]+:16`).
- Load extraction: the lane is zero- or sign-extended to 32 bits. A word load passes the data through unchanged.
- Store merge: only the target lane is replaced with `wdata[7:0]` or `wdata[15:0]`; all other bits come from the captured read word.
- `rdata` holds its value until the next load completes. Stores and errors do not change it.

## Timing
All timings are for RD_LAT=1, with `req` sampled at the edge ending cycle 0.
- Word store: WR in cycle 1 (`mem_wea`=1); `done` in cycle 2.
- Load: RD in cycles 1–2 (capture at the end of cycle 2); `done` and valid `rdata` in cycle 3.
- Sub-word store: RD in cycles 1–2, WR in cycle 3, `done` in cycle 4.
- Misaligned access: `done` and `misaligned` in cycle 1.
- General latencies: load = RD_LAT+2 cycles; sub-word store = RD_LAT+3 cycles.
- `busy` is 1 in RD, WR and DONE, and 0 in IDLE. It is a registered output, decoded from state.
- `mem_wea` is high in exactly one cycle per store, and never for loads or errors.
- Reset values: state IDLE; `busy`, `done`, `misaligned`, `mem_wea` = 0; `rdata`, `mem_addra`, `mem_dina` = 0.
- Reset mid-operation: `mem_wea` drops asynchronously and no `done` is issued. An in-flight read-modify-write is abandoned, so memory keeps its pre-store contents.

## Structure
- Package `mem_access_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
- Sub-module `lane_align` (combinational): takes read word, lane, size, sign_ext and store data. It produces the extracted load value and the merged store word. It is instantiated once.
- The RD wait counter is $clog2(RD_LAT+1) bits wide.

## Test plan
All scenarios use a behavioural Pipedmem model with RD_LAT=1.
- Word store, then word load, at addr 20 (word 5), data 32'hDEADBEEF. Required: `mem_wea` high exactly at cycle 1 with `mem_addra`=5; the load gives `rdata`=32'hDEADBEEF with `done` at cycle 3.
- Byte store of 8'h5A at addr 22 over 32'h11223344. Required: memory word = 32'h115A3344; `done` at cycle 4; single `mem_wea` pulse.
- Load from addr 23 over 32'h80FF0000. Required:
  - byte load, `sign_ext`=1 → 32'hFFFFFF80;
  - byte load, `sign_ext`=0 → 32'h00000080;
  - halfword load at addr 22 with `sign_ext`=1 → 32'hFFFF80FF.
- Misaligned requests:
  - word at addr 21 → `done`=`misaligned`=1 at cycle 1; `mem_wea` never high; `rdata` unchanged;
  - `size`=11 → same response.
- `rst` asserted in cycle 3 of a halfword store. Required: `mem_wea` never high; memory unchanged; `busy`=0 immediately; a new request is accepted normally after reset.
- `req` held high continuously. Required: accesses are serialised, with the next acceptance in the cycle after each `done`; `req` is ignored while `busy`.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] wdata;
    } req_t;

    // Reserved size is treated like any other misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) ||
               (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [4:0]  bpos;
    logic [4:0]  hpos;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bpos = {lane, 3'b000};
    assign hpos = {lane[1], 4'b0000};
    assign bsel = rword[bpos +: 8];
    assign hsel = rword[hpos +: 16];

    always_comb begin
        ldata = rword;
        mword = sdata;
        case (size)
            SZ_BYTE: begin
                ldata = {{24{sign_ext & bsel[7]}}, bsel};
                mword = rword;
                mword[bpos +: 8] = sdata[7:0];
            end
            SZ_HALF: begin
                ldata = {{16{sign_ext & hsel[15]}}, hsel};
                mword = rword;
                mword[hpos +: 16] = sdata[15:0];
            end
            default: begin
                ldata = rword;
                mword = sdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide single-write-enable memory;
// sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic          done,
    output logic          misaligned,
    output logic          mem_wea,
    output logic [31:0]   mem_addra,
    output logic [31:0]   mem_dina,
    input  logic [31:0]   mem_douta
);

    localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    state_t        state, nstate;
    req_t          rq;
    logic [AW-1:0] aq;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic          rd_last;
    logic          req_err;
    logic          req_wstore;
    logic [31:0]   ldata;
    logic [31:0]   mword;

    assign rd_last    = (cnt == CW'(RD_LAT));
    assign req_err    = is_misaligned(size, addr[1:0]);
    assign req_wstore = we && (size == SZ_WORD);

    lane_align u_align (
        .rword    (mem_douta),
        .lane     (aq[1:0]),
        .size     (rq.size),
        .sign_ext (rq.sign_ext),
        .sdata    (rq.wdata),
        .ldata    (ldata),
        .mword    (mword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    // mem_wea decodes straight from state so reset removes it asynchronously.
    always_comb begin
        nstate  = state;
        done    = 1'b0;
        mem_wea = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (req_err)         nstate = ST_DONE;
                    else if (req_wstore) nstate = ST_WR;
                    else                 nstate = ST_RD;
                end
            end
            ST_RD: begin
                if (rd_last) nstate = rq.we ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                mem_wea = 1'b1;
                nstate  = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    assign misaligned = done & err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq        <= '0;
            aq        <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            rdata     <= '0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            busy <= (nstate != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        rq.we       <= we;
                        rq.size     <= size;
                        rq.sign_ext <= sign_ext;
                        rq.wdata    <= wdata;
                        aq          <= addr;
                        err_q       <= req_err;
                        cnt         <= '0;
                        // Errors issue no memory cycle, so the address bus is left alone.
                        if (!req_err) mem_addra <= 32'(addr[AW-1:2]);
                        if (!req_err && req_wstore) mem_dina <= wdata;
                    end
                end
                ST_RD: begin
                    cnt <= cnt + 1'b1;
                    if (rd_last) begin
                        if (rq.we) mem_dina <= mword;
                        else       rdata    <= ldata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: byte-addressed reference memory predicts every response.
module tb_mem_access_unit;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, mem_addra, mem_dina, mem_douta;
    logic        busy, done, misaligned, mem_wea;

    always #5 clk = ~clk;

    mem_access_unit #(.RD_LAT(RD_LAT), .AW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .misaligned(misaligned), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta)
    );

    // Pipedmem model, one cycle read latency
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_wea) mem[mem_addra[5:0]] <= mem_dina;
        mem_douta <= mem[mem_addra[5:0]];
    end

    typedef struct {
        int          done_cyc;
        logic        mis;
        logic [31:0] rd;
        int          wea_n;
        logic [5:0]  widx;
        logic [31:0] word;
    } exp_t;

    logic [7:0]  ref_b [0:63];
    logic [31:0] last_rd = 32'h0;
    exp_t        q[$];
    exp_t        me;
    int checks = 0, errors = 0, cyc = 0, wea_cnt = 0, last_done = -10;
    bit prev_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%0b expected 0", busy);
        end
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, input bit track);
        exp_t        e;
        bit          mis;
        int          nb;
        logic [63:0] v;
        wait_idle();
        if (prev_hold) chk("accept_gap", cyc, last_done + 1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        nb  = 1 << sz;
        if (track) begin
            e.mis   = mis;
            e.widx  = a[7:2];
            e.wea_n = (!mis && w) ? 1 : 0;
            e.done_cyc = cyc + (mis ? 1 : (w && sz == 2'b10) ? 2 : w ? RD_LAT + 3 : RD_LAT + 2);
            if (!mis && w)
                for (int i = 0; i < nb; i++) ref_b[a + i] = d[8*i +: 8];
            if (!mis && !w) begin
                v = 64'h0;
                for (int i = 0; i < nb; i++) v = v | (64'(ref_b[a + i]) << (8 * i));
                if (sx && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
                last_rd = v[31:0];
            end
            e.rd   = last_rd;
            e.word = ref_word(int'(a[7:2]));
            q.push_back(e);
        end
        prev_hold = hold;
        @(posedge clk);
        #1;
        if (hold) begin
            we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
            addr = $urandom_range(0, 63); wdata = $urandom;
        end else begin
            req = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            wea_cnt = 0;
        end else begin
            if (mem_wea) begin
                wea_cnt++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wea_unexpected: mem_wea=1 expected 0");
                end else begin
                    chk("wea_addr", mem_addra, 32'(q[0].widx));
                    chk("wea_data", mem_dina, q[0].word);
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: done=1 expected 0");
                end else begin
                    me = q.pop_front();
                    chk("done_cycle", cyc, me.done_cyc);
                    chk("misaligned", 32'(misaligned), 32'(me.mis));
                    chk("rdata", rdata, me.rd);
                    chk("wea_pulses", wea_cnt, me.wea_n);
                    chk("mem_word", mem[me.widx], me.word);
                    last_done = cyc;
                end
                wea_cnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        for (int w = 0; w < 64; w++) mem[w] = $urandom;
        for (int w = 0; w < 16; w++)
            for (int i = 0; i < 4; i++) ref_b[4*w+i] = mem[w][8*i +: 8];
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mis", 32'(misaligned), 0);
        chk("rst_wea", 32'(mem_wea), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addra", mem_addra, 0);
        chk("rst_dina", mem_dina, 0);
        rst = 1'b0;

        // word store / load at word 5
        issue(1, 2'b10, 0, 20, 32'hDEADBEEF, 0, 1);
        issue(0, 2'b10, 0, 20, 32'h0, 0, 1);
        wait_idle();
        chk("plan_word_load", rdata, 32'hDEADBEEF);

        // byte store read-modify-write
        issue(1, 2'b10, 0, 20, 32'h11223344, 0, 1);
        issue(1, 2'b00, 0, 22, 32'h0000005A, 0, 1);
        wait_idle();
        chk("plan_byte_merge", mem[5], 32'h115A3344);

        // sub-word load extraction
        issue(1, 2'b10, 0, 20, 32'h80FF0000, 0, 1);
        issue(0, 2'b00, 1, 23, 32'h0, 0, 1);
        wait_idle();
        chk("plan_lb_sx", rdata, 32'hFFFFFF80);
        issue(0, 2'b00, 0, 23, 32'h0, 0, 1);
        wait_idle();
        chk("plan_lb_zx", rdata, 32'h00000080);
        issue(0, 2'b01, 1, 22, 32'h0, 0, 1);
        wait_idle();
        chk("plan_lh_sx", rdata, 32'hFFFF80FF);

        // misaligned and reserved size
        issue(0, 2'b10, 0, 21, 32'h0, 0, 1);
        issue(1, 2'b11, 0, 20, 32'h12345678, 0, 1);
        wait_idle();
        chk("plan_err_rdata", rdata, 32'hFFFF80FF);

        // reset in cycle 3 of a halfword store (the WR cycle)
        issue(1, 2'b01, 0, 26, 32'h0000ABCD, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_wea", 32'(mem_wea), 0);
        chk("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        chk("rst_mem_kept", mem[6], ref_word(6));
        issue(0, 2'b01, 1, 26, 32'h0, 0, 1);

        // req held high with random traffic
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  $urandom_range(0, 63), $urandom, (i != 79), 1);
        end

        begin
            int n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
